// File: rtl/fn_bit_packer.sv
// fn_bit_packer: deserialises a 1-bit function stream into WORD_W-bit words.
// Each completed word and its population count go into a single output
// register slot with a valid/ready handshake. The upstream stage cannot be
// stalled, so a word that completes while the slot is still occupied is
// dropped, and the sticky overflow flag is set.
module fn_bit_packer #(
  parameter int WORD_W = 8,
  parameter int CNT_W  = $clog2(WORD_W + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bit_in,
  input  logic              bit_en,
  input  logic              sync,
  output logic [WORD_W-1:0] word_out,
  output logic [CNT_W-1:0]  ones_cnt,
  output logic              word_valid,
  input  logic              word_ready,
  output logic              overflow
);

  // WORD_W >= 2, so the bit counter is always at least one bit wide.
  localparam int BCNT_W = $clog2(WORD_W);
  localparam logic [BCNT_W-1:0] LAST_BIT = BCNT_W'(WORD_W - 1);

  logic [WORD_W-2:0] shreg_reg;
  logic [BCNT_W-1:0] bcnt_reg;
  logic [WORD_W-1:0] word_out_reg;
  logic [CNT_W-1:0]  ones_cnt_reg;
  logic              word_valid_reg;
  logic              overflow_reg;

  logic [WORD_W-1:0] word_next;
  logic [CNT_W-1:0]  pop_next;
  logic              slot_free;
  logic              complete;

  // The candidate word is always the partial word plus the current bit.
  // When this is not a completion cycle, only its low bits are reused
  // as the new partial word. Older bits fall off the top.
  assign word_next = {shreg_reg, bit_in};
  assign slot_free = !word_valid_reg || word_ready;
  // sync clears the count before sampling, so it can never complete a word.
  assign complete  = bit_en && !sync && (bcnt_reg == LAST_BIT);

  // Population count of the candidate word.
  always_comb begin
    pop_next = '0;
    for (int i = 0; i < WORD_W; i++) begin
      pop_next = pop_next + CNT_W'(word_next[i]);
    end
  end

  // Bit collection, output slot handshake, and sticky overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      shreg_reg      <= '0;
      bcnt_reg       <= '0;
      word_out_reg   <= '0;
      ones_cnt_reg   <= '0;
      word_valid_reg <= 1'b0;
      overflow_reg   <= 1'b0;
    end else begin
      // Partial-word tracking.
      if (bit_en) begin
        shreg_reg <= word_next[WORD_W-2:0];
        if (sync) begin
          bcnt_reg <= BCNT_W'(1);
        end else if (complete) begin
          bcnt_reg <= '0;
        end else begin
          bcnt_reg <= bcnt_reg + BCNT_W'(1);
        end
      end else if (sync) begin
        bcnt_reg <= '0;
      end

      // Output slot: a load takes priority over a transfer that empties it.
      if (complete && slot_free) begin
        word_out_reg   <= word_next;
        ones_cnt_reg   <= pop_next;
        word_valid_reg <= 1'b1;
      end else if (word_valid_reg && word_ready) begin
        word_valid_reg <= 1'b0;
      end

      // A completed word that finds the slot occupied is lost.
      if (complete && !slot_free) begin
        overflow_reg <= 1'b1;
      end
    end
  end

  assign word_out   = word_out_reg;
  assign ones_cnt   = ones_cnt_reg;
  assign word_valid = word_valid_reg;
  assign overflow   = overflow_reg;

endmodule

// File: tb/tb_fn_bit_packer.sv
// Directed testbench for fn_bit_packer (WORD_W = 8).
module tb_fn_bit_packer;

  localparam int WORD_W = 8;
  localparam int CNT_W  = $clog2(WORD_W + 1);

  logic              clk;
  logic              rst;
  logic              bit_in;
  logic              bit_en;
  logic              sync;
  logic [WORD_W-1:0] word_out;
  logic [CNT_W-1:0]  ones_cnt;
  logic              word_valid;
  logic              word_ready;
  logic              overflow;

  int checks_cnt;
  int fail_cnt;

  fn_bit_packer #(.WORD_W(WORD_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .bit_in     (bit_in),
    .bit_en     (bit_en),
    .sync       (sync),
    .word_out   (word_out),
    .ones_cnt   (ones_cnt),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .overflow   (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_cnt++;
    if (obs !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, obs);
    end
  endtask

  // One clock edge; outputs are sampled 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    bit_en = 1'b1;
    bit_in = b;
    tick();
    bit_en = 1'b0;
    bit_in = 1'b0;
  endtask

  // MSB first: bit WORD_W-1 of word_out holds the earliest bit.
  task automatic send_bits(input logic [7:0] v, input int n);
    for (int i = 7; i > 7 - n; i--) send_bit(v[i]);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    checks_cnt = 0;
    fail_cnt   = 0;
    rst        = 1'b1;
    bit_in     = 1'b0;
    bit_en     = 1'b0;
    sync       = 1'b0;
    word_ready = 1'b0;
    idle(2);
    rst = 1'b0;

    // Reset state.
    chk("rst_word",  word_out,   8'h00);
    chk("rst_cnt",   ones_cnt,   4'd0);
    chk("rst_valid", word_valid, 1'b0);
    chk("rst_ovf",   overflow,   1'b0);

    // Basic pack: 1,0,1,1,0,0,1,0 -> 0xB2, four ones.
    word_ready = 1'b1;
    send_bits(8'hB2, 7);
    chk("basic_valid_early", word_valid, 1'b0);
    send_bit(1'b0);
    chk("basic_word",  word_out,   8'hB2);
    chk("basic_cnt",   ones_cnt,   4'd4);
    chk("basic_valid", word_valid, 1'b1);
    chk("basic_ovf",   overflow,   1'b0);
    idle(1);
    chk("basic_valid_drop", word_valid, 1'b0);

    // Backpressure and overflow.
    word_ready = 1'b0;
    send_bits(8'hFF, 8);
    chk("bp_word1",  word_out,   8'hFF);
    chk("bp_valid1", word_valid, 1'b1);
    send_bits(8'h00, 7);
    chk("bp_ovf_early", overflow, 1'b0);
    chk("bp_hold_word", word_out, 8'hFF);
    send_bit(1'b0);
    chk("bp_ovf",       overflow, 1'b1);
    chk("bp_hold_word2", word_out, 8'hFF);
    chk("bp_hold_cnt",  ones_cnt, 4'd8);
    word_ready = 1'b1;
    tick();
    word_ready = 1'b0;
    chk("bp_valid_drop", word_valid, 1'b0);
    chk("bp_ovf_sticky", overflow,   1'b1);

    // Simultaneous transfer and completion.
    do_reset();
    chk("sim_ovf_cleared", overflow, 1'b0);
    send_bits(8'h0F, 8);
    chk("sim_first_word", word_out, 8'h0F);
    send_bits(8'h3C, 7);
    chk("sim_hold_0f", word_out, 8'h0F);
    word_ready = 1'b1;
    send_bit(1'b0);
    word_ready = 1'b0;
    chk("sim_word",  word_out,   8'h3C);
    chk("sim_cnt",   ones_cnt,   4'd4);
    chk("sim_valid", word_valid, 1'b1);
    chk("sim_ovf",   overflow,   1'b0);
    idle(1);
    chk("sim_valid_hold", word_valid, 1'b1);
    word_ready = 1'b1;
    tick();
    chk("sim_valid_drop", word_valid, 1'b0);

    // Sync realign: three stray bits, then sync with bit 1, then 0000001.
    send_bits(8'hE0, 3);
    sync = 1'b1;
    send_bit(1'b1);
    sync = 1'b0;
    send_bits(8'h02, 6);
    chk("sync_valid_early", word_valid, 1'b0);
    send_bit(1'b1);
    chk("sync_word",  word_out,   8'h81);
    chk("sync_cnt",   ones_cnt,   4'd2);
    chk("sync_valid", word_valid, 1'b1);
    idle(1);

    // Gapped input: 0xA5 with an idle cycle after every enabled bit.
    begin
      logic [7:0] v;
      v = 8'hA5;
      for (int i = 7; i >= 1; i--) begin
        send_bit(v[i]);
        idle(1);
      end
      chk("gap_valid_early", word_valid, 1'b0);
      send_bit(v[0]);
    end
    chk("gap_word",  word_out,   8'hA5);
    chk("gap_cnt",   ones_cnt,   4'd4);
    chk("gap_valid", word_valid, 1'b1);
    idle(1);

    // Mid-word reset.
    send_bits(8'hF8, 5);
    do_reset();
    chk("mrst_word",  word_out,   8'h00);
    chk("mrst_cnt",   ones_cnt,   4'd0);
    chk("mrst_valid", word_valid, 1'b0);
    chk("mrst_ovf",   overflow,   1'b0);
    send_bits(8'h01, 8);
    chk("mrst_new_word",  word_out,   8'h01);
    chk("mrst_new_cnt",   ones_cnt,   4'd1);
    chk("mrst_new_valid", word_valid, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
    $finish;
  end

endmodule

// File: doc/fn_bit_packer.md
# fn_bit_packer

Downstream consumer of the registered 1-bit function output `y` from the 8-input XOR/AND-OR stage. It deserialises that bit stream into WORD_W-bit words, computes each word's population count, and presents both on a valid/ready output port backed by a single holding register. The upstream stage cannot be stalled, so words that find the output slot occupied are dropped and flagged.

## Interface
- `WORD_W`, default 8: bits per packed word; legal range 2..32.
- `CNT_W`, default $clog2(WORD_W+1): width of `ones_cnt`; derived, do not override.

Ports:
- `clk`  in  1: single clock; all logic rising-edge.
- `rst`  in  1: synchronous, active-high reset.
- `bit_in`  in  1: serial data, connected to upstream `y`.
- `bit_en`  in  1: `bit_in` is valid and is sampled this cycle.
- `sync`  in  1: word alignment; discards any partial word.
- `word_out`  out  WORD_W: packed word; bit WORD_W-1 holds the earliest-received bit.
- `ones_cnt`  out  CNT_W: number of 1s in `word_out`.
- `word_valid`  out  1: `word_out` and `ones_cnt` hold an unconsumed word.
- `word_ready`  in  1: the consumer accepts the word this cycle.
- `overflow`  out  1: sticky; at least one completed word was dropped.

## Operation
- Internal state:
  - `shreg[WORD_W-2:0]`: partial word.
  - `bcnt`: 0..WORD_W-1, bits collected so far.
  - Output slot: `word_out`, `ones_cnt`, `word_valid`.
  - `overflow`.
- **Reset** (`rst`=1 at an edge): `shreg`, `bcnt`, `word_out`, `ones_cnt`, `word_valid` and `overflow` all go to 0. Reset overrides every other input. A partial word in flight is discarded. A word held in the output slot is lost without setting `overflow`.
- **Slot free**: `slot_free = !word_valid || word_ready`, evaluated in the current cycle.
- **Accumulate**: `bit_en`=1 and `bcnt` < WORD_W-1. Shift `bit_in` into the LSB of `shreg` and increment `bcnt`.
- **Complete**: `bit_en`=1 and `bcnt` = WORD_W-1.
  - Form `word = {shreg, bit_in}` and set `bcnt` to 0.
  - If `slot_free`: `word_out` ← `word`, `ones_cnt` ← popcount(`word`), `word_valid` ← 1.
  - Otherwise: drop the word, set `overflow` ← 1, and leave the slot unchanged.
- **Sync**: `sync`=1 clears `bcnt` before sampling. If `bit_en`=1 in the same cycle, `bit_in` becomes bit 0 of a new word, so `bcnt` ends at 1. A completion is never produced in a `sync` cycle, even when `bcnt` was WORD_W-1 (WORD_W≥2). `sync` never touches the output slot or `overflow`.
- **Handshake**:
  - A transfer occurs at an edge where `word_valid`=1 and `word_ready`=1. With no simultaneous completion, `word_valid` ← 0.
  - While `word_valid`=1 and `word_ready`=0, `word_out` and `ones_cnt` are held stable.
  - `word_ready` may be asserted while `word_valid`=0; it has no effect.
- **Simultaneous transfer + completion**: the new word loads, `word_valid` stays 1, and nothing is dropped. The consumer therefore sees back-to-back valid words.
- **`bit_en`=0**: no state change except handshake effects.
- **Overflow**: clears only on `rst`.
- **Popcount**: combinational on `word` and registered alongside it. Maximum value is WORD_W, which fits in CNT_W.

## Timing
- Latency: the edge that samples the WORD_W-th bit also sets `word_valid`. The word is visible in the following cycle.
- Throughput: one word per WORD_W `bit_en` cycles. With `word_ready` held at 1, no word is ever dropped.
- There is no combinational path from inputs to outputs. All outputs are registered.
- `word_valid` drops in the cycle after the transfer edge, unless a completion coincides with that edge.

## Test plan
- **Basic pack**: reset, then `word_ready`=1. Drive `bit_en`=1 with bits 1,0,1,1,0,0,1,0 on consecutive cycles. Required: `word_out`=8'hB2, `ones_cnt`=4, `word_valid`=1 for exactly one cycle, `overflow`=0.
- **Backpressure + overflow**: hold `word_ready`=0 and feed 16 bits, 8'hFF then 8'h00. Required: `word_out` stays 8'hFF with `ones_cnt`=8, and `overflow` rises on the 16th-bit edge. Then pulse `word_ready`; `word_valid` drops and `overflow` stays 1.
- **Simultaneous**: with 8'h0F pending and `ready`=0, stream 8'h3C. Assert `word_ready` only on the edge sampling the 8th bit of 8'h3C. Required: `word_out`=8'h3C, `ones_cnt`=4, `word_valid` stays 1, `overflow`=0.
- **Sync realign**: feed 3 bits, then assert `sync` with `bit_en`=1 and `bit_in`=1, followed by 7 bits 0000001. Required: `word_out`=8'h81, and the three earlier bits are absent.
- **Gapped input**: feed 8'hA5 with `bit_en` deasserted on alternating cycles. Required: `word_out`=8'hA5, `ones_cnt`=4, completion lands on the 8th enabled bit.
- **Mid-word reset**: feed 5 bits, assert `rst` for one cycle, then feed 8'h01. Required: all outputs are 0 during and after reset, then `word_out`=8'h01 with `ones_cnt`=1.
